// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues 1-cycle-latency instruction memory reads
// and buffers {pc, instr} responses in a 2-entry FIFO handed to decode over valid/ready.
module fetch_stage #(
  parameter int unsigned     XLEN     = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PC_we,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready
);

  localparam logic [XLEN-1:0] PcInc = XLEN'(PC_STEP);

  // Program counter and outstanding-request tracking
  logic [XLEN-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_addr_q, inflight_addr_d;

  // 2-entry FIFO storage and bookkeeping
  logic [XLEN-1:0] fifo_pc_q    [2];
  logic [XLEN-1:0] fifo_instr_q [2];
  logic            head_q, head_d;
  logic            tail_q, tail_d;
  logic [1:0]      count_q, count_d;

  // Last presented head, so outputs hold while the FIFO is empty
  logic [XLEN-1:0] last_pc_q, last_instr_q;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] credit;

  assign if_valid = (count_q != 2'd0);
  assign pop      = if_valid && id_ready;

  // Slots already committed after this cycle's pop; an issue needs one free slot
  assign credit = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign issue  = !rst && PC_we && !redirect_valid && (credit < 3'd2);

  assign imem_req  = issue;
  assign imem_addr = pc_q;

  // A response in the redirect cycle belongs to the squashed path
  assign push = inflight_q && !redirect_valid;

  assign if_pc    = if_valid ? fifo_pc_q[head_q]    : last_pc_q;
  assign if_instr = if_valid ? fifo_instr_q[head_q] : last_instr_q;

  always_comb begin
    pc_d            = pc_q;
    inflight_d      = issue;
    inflight_addr_d = inflight_addr_q;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;

    if (redirect_valid) begin
      pc_d       = {redirect_target[XLEN-1:1], 1'b0};
      inflight_d = 1'b0;
      head_d     = 1'b0;
      tail_d     = 1'b0;
      count_d    = 2'd0;
    end else begin
      if (issue) begin
        pc_d            = pc_q + PcInc;
        inflight_addr_d = pc_q;
      end
      if (push) begin
        tail_d = ~tail_q;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= RESET_PC;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      head_q          <= 1'b0;
      tail_q          <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      pc_q            <= pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else if (push) begin
      fifo_pc_q[tail_q]    <= inflight_addr_q;
      fifo_instr_q[tail_q] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_pc_q    <= '0;
      last_instr_q <= '0;
    end else if (if_valid) begin
      last_pc_q    <= fifo_pc_q[head_q];
      last_instr_q <= fifo_instr_q[head_q];
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory responder, sequential-stream reference queue and a monitor
// that checks every accepted beat plus directed checks for each scenario.
module tb_fetch_stage;

  localparam logic [15:0] ResetPc = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PC_we = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_target = 16'h0000;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        id_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int delivered = 0;
  int stall_cycles = 0;

  // Reference model: the delivered stream is the sequential program from the last
  // reset/redirect target, independent of freeze and backpressure.
  logic [31:0] exp_q[$];
  logic [15:0] next_pc = ResetPc;
  logic [15:0] flush_to = ResetPc;
  logic        pend_flush = 1'b0;

  logic        mem_pend = 1'b0;
  logic [15:0] mem_addr_s = 16'h0000;

  logic        hold_v = 1'b0;
  logic [31:0] hold_val = 32'h0;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN    (16),
    .RESET_PC(ResetPc),
    .PC_STEP (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .PC_we          (PC_we),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hA500;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous memory: data for a request in cycle N is presented throughout cycle N+1
  always @(negedge clk) begin
    mem_pend   = (imem_req === 1'b1);
    mem_addr_s = imem_addr;
  end

  always @(posedge clk) begin
    #1;
    imem_rdata = mem_pend ? mem_word(mem_addr_s) : 16'($urandom);
  end

  // Monitor: compares each accepted beat against the reference queue
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      hold_v       = 1'b0;
      stall_cycles = 0;
    end else begin
      if (hold_v) begin
        check("head_hold_valid", 32'(if_valid), 32'd1);
        check("head_hold_entry", {if_pc, if_instr}, hold_val);
      end
      if (if_valid && id_ready) begin
        stall_cycles = 0;
        e = exp_q.pop_front();
        check("deliver_pc_instr", {if_pc, if_instr}, e);
        delivered++;
      end else begin
        stall_cycles++;
      end
      if (stall_cycles > 40) begin
        check("stall_cycles", 32'(stall_cycles), 32'd40);
        stall_cycles = 0;
      end
      hold_v   = if_valid && !id_ready && !redirect_valid;
      hold_val = {if_pc, if_instr};
    end
  end

  // One clock cycle of stimulus; returns at the falling edge for sampling
  task automatic step(input logic r, input logic we, input logic rdy, input logic rv,
                      input logic [15:0] tgt);
    @(posedge clk);
    #1;
    if (pend_flush) begin
      exp_q.delete();
      next_pc    = flush_to;
      pend_flush = 1'b0;
    end
    rst             = r;
    PC_we           = we;
    id_ready        = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    if (r) begin
      flush_to   = ResetPc;
      pend_flush = 1'b1;
    end else if (rv) begin
      flush_to   = {tgt[15:1], 1'b0};
      pend_flush = 1'b1;
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back({next_pc, mem_word(next_pc)});
      next_pc = next_pc + 16'd2;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
  endtask

  initial begin
    logic [15:0] wrap_addrs [4];
    wrap_addrs[0] = 16'hFFFC;
    wrap_addrs[1] = 16'hFFFE;
    wrap_addrs[2] = 16'h0000;
    wrap_addrs[3] = 16'h0002;

    // 1. Reset then stream
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    check("reset_cycle_req", 32'(imem_req), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      check("stream_req", 32'(imem_req), 32'd1);
      check("stream_addr", 32'(imem_addr), 32'(16'(2 * k)));
      check("stream_valid", 32'(if_valid), 32'(k >= 2));
      if (k == 0) check("reset_if_pc_instr", {if_pc, if_instr}, 32'h0);
    end

    // 2. Backpressure: FIFO fills, issue stops, resumes at the next sequential pc
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      check("bp_req_low", 32'(imem_req), 32'd0);
      check("bp_valid", 32'(if_valid), 32'd1);
    end
    for (int r = 0; r < 6; r++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      check("bp_resume_req", 32'(imem_req), 32'd1);
      check("bp_resume_addr", 32'(imem_addr), 32'(16'h0010 + 16'(2 * r)));
    end

    // 3. Freeze with a request in flight
    for (int f = 0; f < 3; f++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
      check("freeze_req_low", 32'(imem_req), 32'd0);
      check("freeze_pc_hold", 32'(imem_addr), 32'h001C);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    check("freeze_resume_req", 32'(imem_req), 32'd1);
    check("freeze_resume_addr", 32'(imem_addr), 32'h001C);
    run(4);

    // 4. Redirect with a response in flight and the FIFO about to fill
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0041);
    check("redir_req_low", 32'(imem_req), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    check("redir_fifo_empty", 32'(if_valid), 32'd0);
    check("redir_req", 32'(imem_req), 32'd1);
    check("redir_addr", 32'(imem_addr), 32'h0040);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    check("redir_latency_empty", 32'(if_valid), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    check("redir_first_valid", 32'(if_valid), 32'd1);
    check("redir_first_pc", 32'(if_pc), 32'h0040);
    run(4);

    // 5. Wrap-around past 16'hFFFE
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFC);
    for (int w = 0; w < 4; w++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
      check("wrap_addr", 32'(imem_addr), 32'(wrap_addrs[w]));
    end
    run(6);

    // 6. Reset mid-operation
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    check("rst_req_low", 32'(imem_req), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    check("rst_next_valid", 32'(if_valid), 32'd0);
    check("rst_next_req", 32'(imem_req), 32'd0);
    check("rst_next_if_pc", 32'(if_pc), 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    check("rst_restart_req", 32'(imem_req), 32'd1);
    check("rst_restart_addr", 32'(imem_addr), 32'(ResetPc));
    check("rst_restart_valid", 32'(if_valid), 32'd0);
    run(6);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic        r, we, rdy, rv;
      logic [15:0] tgt;
      r   = ($urandom_range(0, 149) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      we  = ($urandom_range(0, 99) < 80);
      rdy = ($urandom_range(0, 99) < 75);
      tgt = 16'($urandom);
      step(r, we, rdy, rv, tgt);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);

    check("deliveries_min", 32'(delivered >= 250), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
